ramb_s16_byte_reader: RTL and testbench

Streaming read controller for the 16-bit port (port B) of the 512x8 / 256x16 dual-port block RAM. It drives ENB, ADDRB and WEB to fetch 16-bit words, absorbs the RAM's one-cycle registered read latency in a 2-word buffer, and emits the requested bytes in address order on a valid/ready byte stream. It is the read-side counterpart to byte writers on port A: it sits between the RAM and any byte consumer, such as a UART TX path or a PicoBlaze input port.

---
 rtl/ramb_rd_pkg.sv | 14 +
 rtl/ramb_rd_word_buf.sv | 46 ++++
 rtl/ramb_s16_byte_reader.sv | 128 ++++++++++++
 tb/tb_ramb_s16_byte_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramb_rd_pkg.sv
// Shared types and constants for the port-B byte reader.
// Purpose: state encoding and buffer sizing; no logic lives here.
package ramb_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int RD_LATENCY = 1;
    localparam int WBUF_DEPTH = 2;

endpackage

// File: rtl/ramb_rd_word_buf.sv
// 2-entry 16-bit synchronous FIFO holding RAM words awaiting serialization.
// Latency: head visible the cycle after push; a push into a full buffer is dropped unless a pop coincides.
module ramb_rd_word_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_dat,
    input  logic        pop,
    output logic [1:0]  count,
    output logic [15:0] head
);

    logic [15:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ramb_s16_byte_reader.sv
// Streams bytes in address order from the 16-bit RAM port, first byte 3 cycles after START.
// Backpressure: DOUT holds while READY is low; reads stop once buffered + in-flight words reach 2.
module ramb_s16_byte_reader
    import ramb_rd_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    output logic              web,
    output logic              rstb,
    input  logic [15:0]       dob,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] word_ptr;
    logic              lane;
    logic [LEN_W-1:0]  bytes_rem;
    logic [LEN_W:0]    words_left;
    logic [LEN_W:0]    fetch_init;
    logic              inflight;
    logic [1:0]        buf_count;
    logic [15:0]       buf_head;
    logic              hs;
    logic              pop;
    logic              last_byte;

    assign web  = 1'b0;
    assign rstb = 1'b0;

    // An odd start wastes the low lane of the first word, hence the extra byte in the round-up.
    assign fetch_init = ({{LEN_W{1'b0}}, start_addr[0]} + {1'b0, len} + (LEN_W+1)'(1)) >> 1;

    assign last_byte = (bytes_rem == LEN_W'(1));
    assign hs        = dout_valid && dout_ready;
    assign pop       = hs && (lane || last_byte);
    assign dout_last = dout_valid && last_byte;
    assign dout      = dout_valid ? (lane ? buf_head[15:8] : buf_head[7:0]) : 8'h00;
    assign addrb     = word_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        enb        = 1'b0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                dout_valid = (buf_count != 2'd0);
                enb        = (words_left != '0) &&
                             (({1'b0, buf_count} + {2'b00, inflight}) < 3'(WBUF_DEPTH));
                if (dout_valid && dout_ready && last_byte) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_ptr   <= '0;
            lane       <= 1'b0;
            bytes_rem  <= '0;
            words_left <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= enb;
            if (state == IDLE && start) begin
                word_ptr   <= start_addr[ADDR_W:1];
                lane       <= start_addr[0];
                bytes_rem  <= len;
                words_left <= fetch_init;
            end else begin
                if (enb) begin
                    word_ptr   <= word_ptr + ADDR_W'(1);
                    words_left <= words_left - (LEN_W+1)'(1);
                end
                if (hs) begin
                    bytes_rem <= bytes_rem - LEN_W'(1);
                    lane      <= !pop;
                end
            end
        end
    end

    ramb_rd_word_buf u_word_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_dat (dob),
        .pop      (pop),
        .count    (buf_count),
        .head     (buf_head)
    );

endmodule

// File: tb/tb_ramb_s16_byte_reader.sv
// Bench for ramb_s16_byte_reader with a registered-read RAM model and byte scoreboard.
module tb_ramb_s16_byte_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  start_addr;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic [7:0]  addrb;
    logic        enb;
    logic        web;
    logic        rstb;
    logic [15:0] dob = 16'h0000;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    logic [15:0] ram [256];
    logic [7:0]  exp_q  [$];
    logic [7:0]  addr_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enb) dob <= ram[addrb];
    end

    ramb_s16_byte_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .addrb      (addrb),
        .enb        (enb),
        .web        (web),
        .rstb       (rstb),
        .dob        (dob),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
    );

    function automatic logic [7:0] ram_byte(input logic [8:0] b);
        logic [15:0] w;
        w = ram[b[8:1]];
        return b[0] ? w[15:8] : w[7:0];
    endfunction

    // Drives one transfer starting at the next falling edge (cycle 0) and scores it up to DONE.
    task automatic run_xfer(input logic [8:0] sa, input logic [9:0] ln, input int rmode,
                            input int poke_cyc, output int first_cyc, output int last_cyc,
                            output int done_cyc, output int enb_cnt);
        int         issued;
        int         consumed;
        int         nacc;
        int         nwords;
        logic       prev_stall;
        logic [7:0] prev_dout;
        logic       prev_last;
        logic [7:0] exp_b;
        logic [7:0] wa;
        logic [8:0] b;
        first_cyc = -1; last_cyc = -1; done_cyc = -1; enb_cnt = 0;
        issued = 0; consumed = 0; nacc = 0;
        prev_stall = 1'b0; prev_dout = 8'h00; prev_last = 1'b0;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < int'(ln); i++) begin
            b = sa + 9'(i);
            exp_q.push_back(ram_byte(b));
        end
        nwords = (int'(sa[0]) + int'(ln) + 1) / 2;
        wa = sa[8:1];
        for (int i = 0; i < nwords; i++) begin
            addr_q.push_back(wa);
            wa = wa + 8'd1;
        end
        @(negedge clk);
        start = 1'b1; start_addr = sa; len = ln;
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == poke_cyc) begin
                start = 1'b1; start_addr = 9'h000; len = 10'd1;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0;
            end
            dout_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            checks++;
            if (web !== 1'b0 || rstb !== 1'b0)
                $display("FAIL web_rstb cyc=%0d got web=%b rstb=%b want 0 0", cyc, web, rstb);
            if (web !== 1'b0 || rstb !== 1'b0) errors++;
            if (enb) begin
                enb_cnt++;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL enb_outside_run cyc=%0d busy=%b want 1", cyc, busy);
                end
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read cyc=%0d addrb=%h want no read", cyc, addrb);
                end else begin
                    wa = addr_q.pop_front();
                    if (addrb !== wa) begin
                        errors++;
                        $display("FAIL addrb cyc=%0d got %h want %h", cyc, addrb, wa);
                    end
                end
                checks++;
                if (issued - consumed >= 2) begin
                    errors++;
                    $display("FAIL occupancy cyc=%0d got %0d words held want <2 before issue",
                             cyc, issued - consumed);
                end
                issued++;
            end
            if (dout_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_stall) begin
                    checks++;
                    if (dout !== prev_dout || dout_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got %h/%b want %h/%b",
                                 cyc, dout, dout_last, prev_dout, prev_last);
                    end
                end
                if (dout_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte cyc=%0d got %h want none", cyc, dout);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (dout !== exp_b) begin
                            errors++;
                            $display("FAIL dout cyc=%0d got %h want %h", cyc, dout, exp_b);
                        end
                        checks++;
                        if (dout_last !== (exp_q.size() == 0)) begin
                            errors++;
                            $display("FAIL dout_last cyc=%0d got %b want %b",
                                     cyc, dout_last, exp_q.size() == 0);
                        end
                    end
                    if (dout_last) last_cyc = cyc;
                    b = sa + 9'(nacc);
                    if (b[0] || exp_q.size() == 0) consumed++;
                    nacc++;
                end
                prev_stall = !dout_ready;
                prev_dout  = dout;
                prev_last  = dout_last;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_fin cyc=%0d got %b want 0", cyc, busy);
                end
            end
        end
        dout_ready = 1'b1;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout got no DONE within 300 cycles want DONE");
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d bytes %0d reads outstanding want 0 0",
                     exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, enb, web, rstb, addrb} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b enb=%b web=%b rstb=%b addrb=%h want all 0",
                     busy, done, enb, web, rstb, addrb);
        end
        checks++;
        if ({dout_valid, dout_last, dout} !== 10'd0) begin
            errors++;
            $display("FAIL reset_data got valid=%b last=%b dout=%h want 0 0 00",
                     dout_valid, dout_last, dout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_aligned;
        int f, l, d, e;
        run_xfer(9'h020, 10'd4, 0, -1, f, l, d, e);
        checks++;
        if (f != 3 || l != 6) begin
            errors++;
            $display("FAIL aligned_timing got first=%0d last=%0d want 3 6", f, l);
        end
        checks++;
        if (d != 7 || e != 2) begin
            errors++;
            $display("FAIL aligned_done got done=%0d reads=%0d want 7 2", d, e);
        end
    endtask

    task automatic test_odd;
        int f, l, d, e;
        run_xfer(9'h021, 10'd2, 0, -1, f, l, d, e);
        checks++;
        if (e != 2 || f != 3 || l != 4 || d != 5) begin
            errors++;
            $display("FAIL odd got reads=%0d first=%0d last=%0d done=%0d want 2 3 4 5", e, f, l, d);
        end
    endtask

    task automatic test_backpressure;
        int f, l, d, e;
        run_xfer(9'h021, 10'd6, 1, -1, f, l, d, e);
        checks++;
        if (e != 4) begin
            errors++;
            $display("FAIL bp_reads got %0d want 4", e);
        end
    endtask

    task automatic test_wrap;
        int f, l, d, e;
        run_xfer(9'h1FF, 10'd2, 0, -1, f, l, d, e);
        checks++;
        if (e != 2 || f != 3 || d != 5) begin
            errors++;
            $display("FAIL wrap got reads=%0d first=%0d done=%0d want 2 3 5", e, f, d);
        end
    endtask

    task automatic test_len0;
        int f, l, d, e;
        run_xfer(9'h040, 10'd0, 0, -1, f, l, d, e);
        checks++;
        if (d != 1 || e != 0 || f != -1) begin
            errors++;
            $display("FAIL len0 got done=%0d reads=%0d first=%0d want 1 0 -1", d, e, f);
        end
    endtask

    task automatic test_start_busy;
        int f, l, d, e;
        run_xfer(9'h020, 10'd4, 0, 2, f, l, d, e);
        checks++;
        if (l != 6 || d != 7 || e != 2) begin
            errors++;
            $display("FAIL start_busy got last=%0d done=%0d reads=%0d want 6 7 2", l, d, e);
        end
        // Still in the DONE cycle: this request must be ignored.
        start = 1'b1; start_addr = 9'h020; len = 10'd4;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_fin got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int nacc, f, l, d, e;
        nacc = 0;
        @(negedge clk);
        start = 1'b1; start_addr = 9'h020; len = 10'd6; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && nacc < 3; cyc++) begin
            if (dout_valid) nacc++;
            if (nacc < 3) @(negedge clk);
        end
        checks++;
        if (nacc != 3) begin
            errors++;
            $display("FAIL rst_mid_reach got %0d bytes presented want 3", nacc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, enb, dout_valid, dout_last, dout, addrb} !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got busy=%b done=%b enb=%b valid=%b last=%b dout=%h addrb=%h want all 0",
                     busy, done, enb, dout_valid, dout_last, dout, addrb);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_done got %b want 0", done);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release got done=%b busy=%b want 0 0", done, busy);
        end
        run_xfer(9'h022, 10'd3, 0, -1, f, l, d, e);
        checks++;
        if (e != 2 || f != 3 || d != 6) begin
            errors++;
            $display("FAIL rst_mid_after got reads=%0d first=%0d done=%0d want 2 3 6", e, f, d);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {8'(i) ^ 8'h5A, 8'(i)};
        ram[8'h10] = 16'hBBAA;
        ram[8'h11] = 16'hDDCC;
        ram[8'hFF] = 16'h2211;
        ram[8'h00] = 16'h4433;
        rst_n = 1'b0; start = 1'b0; start_addr = 9'h000; len = 10'd0; dout_ready = 1'b1;
        test_reset();
        test_aligned();
        test_odd();
        test_backpressure();
        test_wrap();
        test_len0();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion by 200000 time units want finish");
        $fatal(1, "watchdog");
    end

endmodule
